mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one single-port memory bus (Wishbone-style cyc/stb/ack) between instruction fetch and the load/store stage. The fetch side replaces the separate instruction ROM port; the load/store side replaces the data RAM port.
- Raises stall requests toward ctrl until every active request has completed.
- Presents the latched results for exactly one release cycle, during which the pipeline advances.
- Data access has priority over fetch, because the load/store instruction is the older one in the pipeline.

Parameters:
- TIMEOUT, 255: bus cycles to wait for ack before abandoning a transfer. Used only with the optional feature.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset (rst=0 resets on the rising clk edge).
- if_ce_i  in  1  fetch request, from pc_reg ce.
- if_addr_i  in  32  fetch address.
- if_data_o  out  32  fetched instruction, valid in the RELEASE cycle.
- stallreq_if_o  out  1  stall request to ctrl for fetch.
- mem_ce_i  in  1  data request.
- mem_we_i  in  1  1=store, 0=load.
- mem_sel_i  in  4  byte lanes.
- mem_addr_i  in  32  data address.
- mem_data_i  in  32  store data.
- mem_data_o  out  32  load data, valid in the RELEASE cycle.
- stallreq_mem_o  out  1  stall request to ctrl for data.
- bus_cyc_o  out  1  bus cycle active.
- bus_stb_o  out  1  bus strobe.
- bus_we_o  out  1  bus write enable.
- bus_sel_o  out  4  bus byte select.
- bus_addr_o  out  32  bus address.
- bus_data_o  out  32  bus write data.
- bus_data_i  in  32  bus read data.
- bus_ack_i  in  1  bus acknowledge.
- bus_err_o  out  1  timeout flag (optional feature only).

Behaviour:
- States: IDLE, BUS_MEM, BUS_IF, RELEASE. State register updates on the rising clk edge.
- Reset (rst=0):
  - state=IDLE.
  - All bus_* outputs 0.
  - if_data_o=0, mem_data_o=0, bus_err_o=0.
  - stallreq_* forced 0 while rst=0.
- Stall requests (combinational):
  - stallreq_mem_o = mem_ce_i & (state!=RELEASE).
  - stallreq_if_o = if_ce_i & (state!=RELEASE).
- IDLE:
  - If mem_ce_i: load bus registers from the mem_* inputs; cyc=stb=1; go to BUS_MEM.
  - Else if if_ce_i: load bus_addr=if_addr_i, we=0, sel=4'b1111, bus_data=0; cyc=stb=1; go to BUS_IF.
  - Else stay in IDLE.
  - Simultaneous requests: mem is always served first.
- BUS_MEM:
  - Bus outputs are held stable until bus_ack_i=1.
  - On ack: if !mem_we_i, latch bus_data_i into mem_data_o; stores leave mem_data_o unchanged. cyc/stb drop on the next edge.
  - If if_ce_i is still high, issue the fetch directly (BUS_IF, no IDLE bubble); otherwise go to RELEASE.
- BUS_IF:
  - On ack: latch bus_data_i into if_data_o; cyc/stb=0; go to RELEASE.
- RELEASE:
  - Lasts one cycle with both stalls low; latched data is stable; then go to IDLE.
- Requesters hold their inputs stable while stalled. The arbiter does not re-sample them mid-transfer.
- Minimum latency, fetch-only with ack in the first strobe cycle: request in IDLE (cycle 0), strobe in cycle 1, RELEASE in cycle 2.
- bus_ack_i is ignored in IDLE and RELEASE.
- Reset mid-transfer: cyc/stb drop at the reset edge, the latched result is discarded, state=IDLE, and a late ack is ignored.

Optional Feature:
- Macro: MEM_BUS_ARBITER_TIMEOUT_EN.
- When defined:
  - The counter clears on entry to BUS_MEM or BUS_IF and increments each cycle without ack.
  - When count==TIMEOUT: drop cyc/stb, latch 0 as the read result, proceed as if acked, and set bus_err_o=1.
  - bus_err_o is sticky until reset.
- When undefined: waits indefinitely for ack; bus_err_o tied 0; no counter logic.

Decomposition:
- In defines.v:
  - State encodings.
  - `SelAll 4'b1111.
  - `ZeroWord reuse.
  - `BusCycEnable / `BusCycDisable.
- One sub-module is natural: mem_bus_timer (counter plus compare), instantiated only under MEM_BUS_ARBITER_TIMEOUT_EN.

Test Plan:
- Fetch-only read, if_addr_i=0x00000100, ack 2 cycles after stb with data 0x34010001 -> bus_addr_o=0x100, we=0, sel=1111; stallreq_if_o high for 3 cycles then low for 1 cycle with if_data_o=0x34010001.
- Simultaneous load (0x00000200) and fetch (0x00000104), ack 1 cycle each -> bus_addr_o sequence 0x200 then 0x104 with no IDLE gap; both stalls drop together in one RELEASE cycle.
- Store, mem_sel_i=0011, data 0x0000BEEF, addr 0x300 -> bus_we_o=1, bus_sel_o=0011, bus_data_o=0x0000BEEF; mem_data_o unchanged.
- rst=0 asserted during BUS_MEM before ack -> bus_cyc_o=bus_stb_o=0 and state=IDLE after the edge; an ack arriving one cycle later causes no output change.
- With MEM_BUS_ARBITER_TIMEOUT_EN, TIMEOUT=4, ack never asserted -> stb high for 4 cycles then dropped; mem_data_o=0; bus_err_o=1 and stays high until rst=0.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS_MEM = 2'd1,
    BUS_IF  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [3:0]  SEL_ALL       = 4'b1111;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic        BUS_CYC_EN    = 1'b1;
  localparam logic        BUS_CYC_DIS   = 1'b0;

endpackage

// File: rtl/mem_bus_timer.sv
// Ack timeout counter; only built when MEM_BUS_ARBITER_TIMEOUT_EN is defined.
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
module mem_bus_timer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic ack,
  output logic expire
);

  logic [CNT_W-1:0] count;

  // Fires on the TIMEOUT-th consecutive strobe cycle without ack.
  assign expire = run & ~ack & (count == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst || !run || ack || expire) count <= '0;
    else                               count <= count + 1'b1;
  end

endmodule
`endif

// File: rtl/mem_bus_arbiter.sv
// Shares one Wishbone-style bus between fetch and load/store; data wins ties.
// Optional ack timeout enabled by MEM_BUS_ARBITER_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        stallreq_if_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        stallreq_mem_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_data_o,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  if (TIMEOUT >= (1 << CNT_W)) begin : g_bad_cfg
    $error("CNT_W too narrow to hold TIMEOUT");
  end

  state_t      state;
  logic        cyc;
  logic        done;
  logic [31:0] rdata;

  assign bus_cyc_o = cyc;
  assign bus_stb_o = cyc;

  assign stallreq_mem_o = rst & mem_ce_i & (state != RELEASE);
  assign stallreq_if_o  = rst & if_ce_i  & (state != RELEASE);

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  logic expire;
  logic err;

  mem_bus_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (cyc),
    .ack    (bus_ack_i),
    .expire (expire)
  );

  // An abandoned transfer completes like an ack that returned zero.
  assign done      = bus_ack_i | expire;
  assign rdata     = bus_ack_i ? bus_data_i : ZERO_WORD;
  assign bus_err_o = err;

  always_ff @(posedge clk) begin
    if (!rst)        err <= 1'b0;
    else if (expire) err <= 1'b1;
  end
`else
  assign done      = bus_ack_i;
  assign rdata     = bus_data_i;
  assign bus_err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cyc        <= BUS_CYC_DIS;
      bus_we_o   <= 1'b0;
      bus_sel_o  <= '0;
      bus_addr_o <= ZERO_WORD;
      bus_data_o <= ZERO_WORD;
      if_data_o  <= ZERO_WORD;
      mem_data_o <= ZERO_WORD;
    end else begin
      case (state)
        IDLE: begin
          if (mem_ce_i) begin
            bus_addr_o <= mem_addr_i;
            bus_we_o   <= mem_we_i;
            bus_sel_o  <= mem_sel_i;
            bus_data_o <= mem_data_i;
            cyc        <= BUS_CYC_EN;
            state      <= BUS_MEM;
          end else if (if_ce_i) begin
            bus_addr_o <= if_addr_i;
            bus_we_o   <= 1'b0;
            bus_sel_o  <= SEL_ALL;
            bus_data_o <= ZERO_WORD;
            cyc        <= BUS_CYC_EN;
            state      <= BUS_IF;
          end
        end
        BUS_MEM: begin
          if (done) begin
            if (!bus_we_o) mem_data_o <= rdata;
            // Chain straight into a pending fetch without an IDLE bubble.
            if (if_ce_i) begin
              bus_addr_o <= if_addr_i;
              bus_we_o   <= 1'b0;
              bus_sel_o  <= SEL_ALL;
              bus_data_o <= ZERO_WORD;
              state      <= BUS_IF;
            end else begin
              cyc   <= BUS_CYC_DIS;
              state <= RELEASE;
            end
          end
        end
        BUS_IF: begin
          if (done) begin
            if_data_o <= rdata;
            cyc       <= BUS_CYC_DIS;
            state     <= RELEASE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: random transactions, bus slave model, reset and timeout cases.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_ce_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_data_o;
  logic        stallreq_if_o;
  logic        mem_ce_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [3:0]  mem_sel_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_data_i = '0;
  logic [31:0] mem_data_o;
  logic        stallreq_mem_o;
  logic        bus_cyc_o, bus_stb_o, bus_we_o, bus_err_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o, bus_data_o;
  logic [31:0] bus_data_i = '0;
  logic        bus_ack_i = 1'b0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .stallreq_if_o(stallreq_if_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .mem_data_o(mem_data_o), .stallreq_mem_o(stallreq_mem_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_data_i(bus_data_i),
    .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
  } xfer_t;

  typedef struct {
    logic [31:0] mem_data;
    logic [31:0] if_data;
  } rel_t;

  xfer_t bus_exp[$];
  xfer_t slave_q[$];
  rel_t  rel_exp[$];

  int checks = 0;
  int errors = 0;
  bit quiet  = 1'b1;
  logic [31:0] m_mem = '0;
  logic [31:0] m_if  = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Bus slave: acks each transfer after its scheduled number of wait cycles.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (!quiet) begin
        bus_ack_i = 1'b0;
        if (bus_cyc_o && bus_stb_o && slave_q.size() > 0) begin
          if (cnt >= slave_q[0].delay) begin
            bus_ack_i  = 1'b1;
            bus_data_i = slave_q[0].rdata;
            void'(slave_q.pop_front());
            cnt = 0;
          end else begin
            cnt++;
            bus_data_i = $urandom;
          end
        end
      end
    end
  end

  // Monitor: bus fields against expected transfers, results in the release cycle.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!quiet && rst) begin
        if (bus_cyc_o) begin
          if (bus_exp.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_cyc: got cyc=1 expected no transfer");
          end else begin
            chk("bus_stb",  {31'b0, bus_stb_o}, 32'd1);
            chk("bus_addr", bus_addr_o, bus_exp[0].addr);
            chk("bus_we",   {31'b0, bus_we_o}, {31'b0, bus_exp[0].we});
            chk("bus_sel",  {28'b0, bus_sel_o}, {28'b0, bus_exp[0].sel});
            chk("bus_wdata", bus_data_o, bus_exp[0].wdata);
            if (bus_ack_i) void'(bus_exp.pop_front());
          end
        end
        if (mem_ce_i && if_ce_i)
          chk("stall_pair", {31'b0, stallreq_if_o}, {31'b0, stallreq_mem_o});
        if ((mem_ce_i || if_ce_i) && !stallreq_mem_o && !stallreq_if_o) begin
          if (rel_exp.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_release: got release expected none");
          end else begin
            chk("rel_mem_data", mem_data_o, rel_exp[0].mem_data);
            chk("rel_if_data",  if_data_o,  rel_exp[0].if_data);
            void'(rel_exp.pop_front());
          end
        end
      end
    end
  end

  function automatic xfer_t rnd_xfer();
    xfer_t x;
    x.addr  = $urandom;
    x.we    = 1'($urandom_range(0, 1));
    x.sel   = 4'($urandom_range(1, 15));
    x.wdata = $urandom;
    x.delay = $urandom_range(0, 3);
    x.rdata = $urandom;
    return x;
  endfunction

  // Called one step after a rising edge with the arbiter idle.
  task automatic issue(input bit dm, input xfer_t mx, input bit di, input xfer_t ix);
    xfer_t fx;
    int exp_lat = 1;
    int k = 0;
    if (dm) begin
      bus_exp.push_back(mx);
      slave_q.push_back(mx);
      if (!mx.we) m_mem = mx.rdata;
      exp_lat += mx.delay + 1;
    end
    if (di) begin
      fx = ix;
      fx.we = 1'b0; fx.sel = 4'b1111; fx.wdata = '0;
      bus_exp.push_back(fx);
      slave_q.push_back(fx);
      m_if = fx.rdata;
      exp_lat += fx.delay + 1;
    end
    rel_exp.push_back('{mem_data: m_mem, if_data: m_if});
    mem_ce_i = dm; mem_we_i = mx.we; mem_sel_i = mx.sel;
    mem_addr_i = mx.addr; mem_data_i = mx.wdata;
    if_ce_i = di; if_addr_i = ix.addr;
    while (k < 60) begin
      @(negedge clk);
      #2;
      if (!stallreq_mem_o && !stallreq_if_o) break;
      k++;
    end
    chk("latency", k, exp_lat);
    @(posedge clk);
    #1;
    mem_ce_i = 1'b0; if_ce_i = 1'b0;
    mem_addr_i = $urandom; if_addr_i = $urandom;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    xfer_t a, b;
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    xfer_t a, b;
    int n;
    // Stalls must be forced low while reset is held, even with requests up.
    mem_ce_i = 1'b1; if_ce_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall_mem", {31'b0, stallreq_mem_o}, 32'd0);
    chk("rst_stall_if",  {31'b0, stallreq_if_o},  32'd0);
    chk("rst_cyc",       {31'b0, bus_cyc_o},      32'd0);
    chk("rst_stb",       {31'b0, bus_stb_o},      32'd0);
    chk("rst_bus_addr",  bus_addr_o, 32'd0);
    chk("rst_mem_data",  mem_data_o, 32'd0);
    chk("rst_if_data",   if_data_o,  32'd0);
    chk("rst_err",       {31'b0, bus_err_o}, 32'd0);
    mem_ce_i = 1'b0; if_ce_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    quiet = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    a = rnd_xfer();
    b = rnd_xfer();
    b.addr = 32'h0000_0100; b.delay = 1; b.rdata = 32'h3401_0001;
    issue(1'b0, a, 1'b1, b);

    a = rnd_xfer(); a.addr = 32'h0000_0200; a.we = 1'b0; a.delay = 0;
    b = rnd_xfer(); b.addr = 32'h0000_0104; b.delay = 0;
    issue(1'b1, a, 1'b1, b);

    a = rnd_xfer(); a.addr = 32'h0000_0300; a.we = 1'b1; a.sel = 4'b0011;
    a.wdata = 32'h0000_BEEF;
    issue(1'b1, a, 1'b0, b);

    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(1, 3);
      issue(n[0], rnd_xfer(), n[1], rnd_xfer());
    end

    // Reset in the middle of a load, then a late ack with nothing outstanding.
    quiet = 1'b1;
    bus_ack_i = 1'b0;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0200; mem_sel_i = 4'b1111;
    @(posedge clk);
    #1;
    chk("pre_rst_cyc", {31'b0, bus_cyc_o}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_stall", {31'b0, stallreq_mem_o}, 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_cyc", {31'b0, bus_cyc_o}, 32'd0);
    chk("mid_rst_stb", {31'b0, bus_stb_o}, 32'd0);
    rst = 1'b1; mem_ce_i = 1'b0;
    bus_ack_i = 1'b1; bus_data_i = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus_ack_i = 1'b0;
    @(posedge clk);
    #1;
    chk("late_ack_mem_data", mem_data_o, 32'd0);
    chk("late_ack_if_data",  if_data_o,  32'd0);
    chk("late_ack_cyc",      {31'b0, bus_cyc_o}, 32'd0);
    bus_exp.delete(); slave_q.delete(); rel_exp.delete();
    m_mem = '0; m_if = '0;
    quiet = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n = $urandom_range(1, 3);
      issue(n[0], rnd_xfer(), n[1], rnd_xfer());
    end

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    // No ack ever: four strobe cycles, zero result, sticky error flag.
    quiet = 1'b1;
    bus_ack_i = 1'b0;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0400;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      #2;
      if (bus_stb_o) n++;
      if (!stallreq_mem_o) break;
    end
    chk("to_stb_cycles", n, 32'd4);
    chk("to_mem_data", mem_data_o, 32'd0);
    chk("to_err", {31'b0, bus_err_o}, 32'd1);
    @(posedge clk);
    #1;
    mem_ce_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("to_err_sticky", {31'b0, bus_err_o}, 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("to_err_cleared", {31'b0, bus_err_o}, 32'd0);
`else
    chk("err_tied_low", {31'b0, bus_err_o}, 32'd0);
`endif

    if (bus_exp.size() != 0 || rel_exp.size() != 0) begin
      checks++; errors++;
      $display("FAIL leftover: got %0d/%0d pending expected 0/0", bus_exp.size(), rel_exp.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
